// File: rtl/spi_target_regfile_if.sv
// spi_target_regfile_if: SPI bus between an initiator (master) and the register-file target (slave)
interface spi_target_regfile_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
  modport slave (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI mode-0 target with an 8-bit register file and host read port; SPI_TGT_ERRCNT_EN adds a saturating err_cnt output
module spi_target_regfile #(
  parameter int DEPTH = 16,
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst,
  spi_target_regfile_if.slave spi,
  input  logic [6:0] reg_addr,
  output logic [7:0] reg_rdata,
  output logic wr_evt,
  output logic rd_evt,
  output logic err
`ifdef SPI_TGT_ERRCNT_EN
  , output logic [7:0] err_cnt
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LIM = 8'(DEPTH);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_FF-1:0] sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic rise, fall, cs_rise, cs_fall;
  logic [4:0] cnt, cnt_n;
  logic [6:0] sh, sh_n;
  logic [7:0] cmd, cmd_n, sout, sout_n, din, ecnt;
  logic miso_q, oe_q, miso_n, oe_n, wr_n, rd_n, err_n, hit;
  logic [7:0] regs [1<<AW];

  function automatic logic ok(input logic [6:0] a);
    return {1'b0, a} < LIM;
  endfunction

  assign rise = sclk_s[SYNC_FF-1] & ~sclk_d;
  assign fall = ~sclk_s[SYNC_FF-1] & sclk_d;
  assign cs_rise = cs_s[SYNC_FF-1] & ~cs_d;
  assign cs_fall = ~cs_s[SYNC_FF-1] & cs_d;
  assign din = {sh, mosi_s[SYNC_FF-1]};
  assign spi.miso = miso_q;
  assign spi.miso_oe = oe_q;

  // synchronisers reset cs_n low so a frame already running at reset release never sees a falling edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_s <= '0;
      cs_s <= '0;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_FF-2:0], spi.sclk};
      cs_s <= {cs_s[SYNC_FF-2:0], spi.cs_n};
      mosi_s <= {mosi_s[SYNC_FF-2:0], spi.mosi};
      sclk_d <= sclk_s[SYNC_FF-1];
      cs_d <= cs_s[SYNC_FF-1];
    end

  // frame state and shift registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      cmd <= '0;
      sout <= '0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      wr_evt <= 1'b0;
      rd_evt <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      cmd <= cmd_n;
      sout <= sout_n;
      miso_q <= miso_n;
      oe_q <= oe_n;
      wr_evt <= wr_n;
      rd_evt <= rd_n;
      err <= err_n;
    end

  // frame decode: cmd byte selects direction/address, read data is snapshotted at cmd decode
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    cmd_n = cmd;
    sout_n = sout;
    miso_n = miso_q;
    oe_n = oe_q;
    wr_n = 1'b0;
    rd_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        miso_n = 1'b0;
        oe_n = 1'b0;
        if (cs_fall) begin
          state_n = CMD;
          cnt_n = '0;
        end
      end
      CMD:
        if (cs_rise) begin
          state_n = IDLE;
          err_n = cnt != 5'd0;
        end else if (rise) begin
          sh_n = din[6:0];
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cmd_n = din;
            state_n = DATA;
            rd_n = !din[7];
            err_n = !din[7] && !hit && !ok(din[6:0]);
            sout_n = hit ? ecnt : ok(din[6:0]) ? regs[din[AW-1:0]] : 8'h00;
          end
        end
      DATA:
        if (cs_rise) begin
          state_n = IDLE;
          err_n = 1'b1;
          oe_n = 1'b0;
          miso_n = 1'b0;
        end else if (rise) begin
          sh_n = din[6:0];
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd15) begin
            state_n = DONE;
            miso_n = 1'b0;
            wr_n = cmd[7] && ok(cmd[6:0]);
            err_n = cmd[7] && !ok(cmd[6:0]);
          end
        end else if (fall && !cmd[7]) begin
          oe_n = 1'b1;
          miso_n = sout[7];
          sout_n = {sout[6:0], 1'b0};
        end
      DONE: begin
        miso_n = 1'b0;
        if (cs_rise) begin
          state_n = IDLE;
          oe_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // register file: write commits on the 16th rising edge, together with wr_evt
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < (1 << AW); i++) regs[i] <= '0;
    else if (wr_n) regs[cmd[AW-1:0]] <= din;

  // host read port, out-of-range addresses read as zero
  always_ff @(posedge clk or posedge rst)
    if (rst) reg_rdata <= '0;
    else reg_rdata <= ok(reg_addr) ? regs[reg_addr[AW-1:0]] : 8'h00;

`ifdef SPI_TGT_ERRCNT_EN
  // saturating count of err pulses, cleared only by rst
  always_ff @(posedge clk or posedge rst)
    if (rst) ecnt <= '0;
    else if (err && ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
  assign err_cnt = ecnt;
  assign hit = din[6:0] == 7'h7F;
`else
  assign ecnt = '0;
  assign hit = 1'b0;
`endif
endmodule
